// File: rtl/core_biu_arbiter_pkg.sv
// Shared definitions for the core bus interface unit (BIU) arbiter.
//   - Core-level widths used as defaults for the BIU address/data widths.
//   - FSM state encodings BIU_IDLE / BIU_REQ / BIU_RSP (2 bits).
//   - Owner encoding: BIU_OWN_IFU = 0, BIU_OWN_LSU = 1. The owner value also
//     serves as the grant index into the two-bit request/grant vectors.
package core_biu_arbiter_pkg;

    localparam int CORE_PC_WIDTH = 32;
    localparam int CORE_XLEN     = 32;

    localparam logic [1:0] BIU_IDLE = 2'd0;
    localparam logic [1:0] BIU_REQ  = 2'd1;
    localparam logic [1:0] BIU_RSP  = 2'd2;

    localparam logic BIU_OWN_IFU = 1'b0;
    localparam logic BIU_OWN_LSU = 1'b1;

endpackage

// File: rtl/core_biu_rr_arb2.sv
// Combinational two-way round-robin arbiter.
// Ports:
//   req[1:0]    in   request vector, bit 0 = IFU, bit 1 = LSU
//   last_grant  in   owner encoding of the most recent grant
//   gnt[1:0]    out  one-hot grant (all zero when nothing is requested)
// When both requesters are pending, the one that did not win last time is
// granted. A lone requester is always granted.
module core_biu_rr_arb2
    import core_biu_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        if (req == 2'b11) begin
            gnt = (last_grant == BIU_OWN_IFU) ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/core_biu_arbiter.sv
// Shares one memory bus port between the instruction-fetch unit (IFU) and the
// load/store unit (LSU). One transaction is in flight at a time; all channels
// use valid/ready handshakes.
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   ifu_req_*                  IFU fetch request (valid/ready/addr)
//   ifu_rsp_*                  IFU response (valid/ready/data/err)
//   ifu_flush                  pipeline flush; makes an in-flight fetch stale
//   lsu_req_*                  LSU request (valid/ready/addr/wen/wdata/wstrb)
//   lsu_rsp_*                  LSU response (valid/ready/data/err)
//   mem_req_*                  shared memory request channel
//   mem_rsp_*                  shared memory response channel
//   busy                       high whenever the FSM is not idle
// Flow: IDLE accepts one request -> REQ presents it to memory -> RSP routes
// the memory response to its owner, or silently consumes it if a flush made
// the fetch stale.
module core_biu_arbiter
    import core_biu_arbiter_pkg::*;
#(
    parameter int AW = CORE_PC_WIDTH,
    parameter int DW = CORE_XLEN
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            ifu_req_valid,
    output logic            ifu_req_ready,
    input  logic [AW-1:0]   ifu_req_addr,
    output logic            ifu_rsp_valid,
    input  logic            ifu_rsp_ready,
    output logic [DW-1:0]   ifu_rsp_data,
    output logic            ifu_rsp_err,
    input  logic            ifu_flush,

    input  logic            lsu_req_valid,
    output logic            lsu_req_ready,
    input  logic [AW-1:0]   lsu_req_addr,
    input  logic            lsu_req_wen,
    input  logic [DW-1:0]   lsu_req_wdata,
    input  logic [DW/8-1:0] lsu_req_wstrb,
    output logic            lsu_rsp_valid,
    input  logic            lsu_rsp_ready,
    output logic [DW-1:0]   lsu_rsp_data,
    output logic            lsu_rsp_err,

    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [AW-1:0]   mem_req_addr,
    output logic            mem_req_wen,
    output logic [DW-1:0]   mem_req_wdata,
    output logic [DW/8-1:0] mem_req_wstrb,
    input  logic            mem_rsp_valid,
    output logic            mem_rsp_ready,
    input  logic [DW-1:0]   mem_rsp_data,
    input  logic            mem_rsp_err,

    output logic            busy
);

    logic [1:0]      state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_grant_q, last_grant_d;
    logic            discard_q, discard_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            wen_q, wen_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW/8-1:0] wstrb_q, wstrb_d;

    logic [1:0] arb_req;
    logic [1:0] arb_gnt;
    logic       rsp_fire;

    // A fetch is not eligible while a flush is being signalled.
    assign arb_req = {lsu_req_valid, ifu_req_valid & ~ifu_flush};

    core_biu_rr_arb2 u_rr_arb2 (
        .req        (arb_req),
        .last_grant (last_grant_q),
        .gnt        (arb_gnt)
    );

    // Response payload goes straight through; only the valids are steered.
    assign ifu_rsp_data = mem_rsp_data;
    assign ifu_rsp_err  = mem_rsp_err;
    assign lsu_rsp_data = mem_rsp_data;
    assign lsu_rsp_err  = mem_rsp_err;

    assign mem_req_addr  = addr_q;
    assign mem_req_wen   = wen_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wstrb = wstrb_q;

    assign busy     = (state_q != BIU_IDLE);
    assign rsp_fire = mem_rsp_valid & mem_rsp_ready;

    always_comb begin
        // NOTE: every signal assigned below gets a default first so no path
        // leaves it unassigned; a missing default would infer a latch.
        state_d       = state_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        discard_d     = discard_q;
        addr_d        = addr_q;
        wen_d         = wen_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        mem_req_valid = 1'b0;
        mem_rsp_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_rsp_valid = 1'b0;

        case (state_q)
            BIU_IDLE: begin
                ifu_req_ready = arb_gnt[BIU_OWN_IFU];
                lsu_req_ready = arb_gnt[BIU_OWN_LSU];
                if (ifu_req_valid && ifu_req_ready) begin
                    addr_d       = ifu_req_addr;
                    wen_d        = 1'b0;
                    wdata_d      = '0;
                    wstrb_d      = '1;
                    owner_d      = BIU_OWN_IFU;
                    last_grant_d = BIU_OWN_IFU;
                    state_d      = BIU_REQ;
                end else if (lsu_req_valid && lsu_req_ready) begin
                    addr_d       = lsu_req_addr;
                    wen_d        = lsu_req_wen;
                    wdata_d      = lsu_req_wdata;
                    wstrb_d      = lsu_req_wstrb;
                    owner_d      = BIU_OWN_LSU;
                    last_grant_d = BIU_OWN_LSU;
                    state_d      = BIU_REQ;
                end
            end

            BIU_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = BIU_RSP;
                end
            end

            BIU_RSP: begin
                if (owner_q == BIU_OWN_LSU) begin
                    lsu_rsp_valid = mem_rsp_valid;
                    mem_rsp_ready = lsu_rsp_ready;
                end else begin
                    // A stale fetch is drained without involving the IFU.
                    ifu_rsp_valid = mem_rsp_valid & ~discard_q;
                    mem_rsp_ready = discard_q | ifu_rsp_ready;
                end
                if (rsp_fire) begin
                    state_d = BIU_IDLE;
                end
            end

            default: begin
                state_d = BIU_IDLE;
            end
        endcase

        // Flush marks an in-flight fetch stale; completing the response clears
        // the mark and takes priority over a flush in that same cycle.
        if (state_q != BIU_IDLE && owner_q == BIU_OWN_IFU && ifu_flush) begin
            discard_d = 1'b1;
        end
        if (state_q == BIU_RSP && rsp_fire) begin
            discard_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= BIU_IDLE;
            owner_q      <= BIU_OWN_IFU;
            last_grant_q <= BIU_OWN_IFU;
            discard_q    <= 1'b0;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            discard_q    <= discard_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
        end
    end

endmodule
